// File: rtl/dft_peak_detect.sv
// rtl/dft_peak_detect.sv - per-bin power stream and peak-bin search over one DFT spectrum
// A snapshot is taken on accept, then one bin per cycle is squared, streamed and compared.
module dft_peak_detect #(
  parameter int ACCUM_WIDTH = 48,
  parameter int NUM_BINS    = 16,
  parameter int PRE_SHIFT   = 16,
  localparam int BIN_W       = $clog2(NUM_BINS),
  localparam int OP_W        = ACCUM_WIDTH - PRE_SHIFT,
  localparam int POWER_WIDTH = 2*OP_W + 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          valid_i,
  input  logic signed [ACCUM_WIDTH-1:0] A_real_i [NUM_BINS],
  input  logic signed [ACCUM_WIDTH-1:0] A_imag_i [NUM_BINS],
  output logic                          power_valid_o,
  output logic [BIN_W-1:0]              power_bin_o,
  output logic [POWER_WIDTH-1:0]        power_o,
  output logic                          peak_valid_o,
  input  logic                          peak_ready_i,
  output logic [BIN_W-1:0]              peak_bin_o,
  output logic [POWER_WIDTH-1:0]        peak_power_o,
  output logic                          busy_o,
  output logic                          drop_o
);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
  typedef logic signed [OP_W-1:0]   op_t;
  typedef logic signed [2*OP_W-1:0] sq_t;
  typedef logic [POWER_WIDTH-1:0]   pw_t;

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);

  state_t                        r_state;
  logic signed [ACCUM_WIDTH-1:0] r_re [NUM_BINS];
  logic signed [ACCUM_WIDTH-1:0] r_im [NUM_BINS];
  logic [BIN_W-1:0]              r_cnt;
  logic [BIN_W-1:0]              r_best_bin;
  pw_t                           r_best_pow;

  sq_t              w_tr, w_ti, w_sq_r, w_sq_i;
  pw_t              w_power, w_new_pow;
  logic             w_take, w_accept;
  logic [BIN_W-1:0] w_new_bin;

  // Truncating to OP_W after the arithmetic shift is lossless; then widen so the square cannot overflow.
  assign w_tr    = sq_t'(op_t'(r_re[r_cnt] >>> PRE_SHIFT));
  assign w_ti    = sq_t'(op_t'(r_im[r_cnt] >>> PRE_SHIFT));
  assign w_sq_r  = w_tr * w_tr;
  assign w_sq_i  = w_ti * w_ti;
  assign w_power = pw_t'(w_sq_r) + pw_t'(w_sq_i);

  assign w_take    = (r_cnt == '0) || (w_power > r_best_pow);
  assign w_new_bin = w_take ? r_cnt : r_best_bin;
  assign w_new_pow = w_take ? w_power : r_best_pow;
  assign w_accept  = valid_i && ((r_state == IDLE) || ((r_state == HOLD) && peak_ready_i));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_best_bin    <= '0;
      r_best_pow    <= '0;
      for (int i = 0; i < NUM_BINS; i++) begin
        r_re[i] <= '0;
        r_im[i] <= '0;
      end
      power_valid_o <= 1'b0;
      power_bin_o   <= '0;
      power_o       <= '0;
      peak_valid_o  <= 1'b0;
      peak_bin_o    <= '0;
      peak_power_o  <= '0;
      busy_o        <= 1'b0;
      drop_o        <= 1'b0;
    end else begin
      power_valid_o <= 1'b0;
      drop_o        <= 1'b0;
      case (r_state)
        SCAN: begin
          power_valid_o <= 1'b1;
          power_bin_o   <= r_cnt;
          power_o       <= w_power;
          r_best_bin    <= w_new_bin;
          r_best_pow    <= w_new_pow;
          if (valid_i) drop_o <= 1'b1;
          if (r_cnt == LAST_BIN) begin
            r_state      <= HOLD;
            peak_valid_o <= 1'b1;
            peak_bin_o   <= w_new_bin;
            peak_power_o <= w_new_pow;
          end else begin
            r_cnt <= r_cnt + BIN_W'(1);
          end
        end
        HOLD: begin
          if (peak_ready_i) begin
            peak_valid_o <= 1'b0;
            r_state      <= IDLE;
            busy_o       <= 1'b0;
          end else if (valid_i) begin
            drop_o <= 1'b1;
          end
        end
        default: ;
      endcase
      // Accept overrides the HOLD->IDLE return so a handshake can chain straight into a new scan.
      if (w_accept) begin
        for (int i = 0; i < NUM_BINS; i++) begin
          r_re[i] <= A_real_i[i];
          r_im[i] <= A_imag_i[i];
        end
        r_cnt      <= '0;
        r_best_bin <= '0;
        r_best_pow <= '0;
        r_state    <= SCAN;
        busy_o     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dft_peak_detect.sv
// tb/tb_dft_peak_detect.sv - scoreboard bench for dft_peak_detect
// Stimulus pushes expected strobes and peaks; a negedge monitor pops and compares.
module tb_dft_peak_detect;
  localparam int AW = 48;
  localparam int NB = 16;
  localparam int PS = 16;
  localparam int BW = 4;
  localparam int PW = 2*(AW-PS) + 1;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic valid_i = 1'b0;
  logic peak_ready_i = 1'b1;
  logic signed [AW-1:0] a_re [NB];
  logic signed [AW-1:0] a_im [NB];
  logic          power_valid_o, peak_valid_o, busy_o, drop_o;
  logic [BW-1:0] power_bin_o, peak_bin_o;
  logic [PW-1:0] power_o, peak_power_o;

  typedef struct { int bin; logic [PW-1:0] pw; } exp_t;
  exp_t pq[$];
  exp_t kq[$];
  int n_cmp = 0;
  int n_err = 0;
  int drop_cnt = 0;

  dft_peak_detect #(.ACCUM_WIDTH(AW), .NUM_BINS(NB), .PRE_SHIFT(PS)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i),
    .A_real_i(a_re), .A_imag_i(a_im),
    .power_valid_o(power_valid_o), .power_bin_o(power_bin_o), .power_o(power_o),
    .peak_valid_o(peak_valid_o), .peak_ready_i(peak_ready_i),
    .peak_bin_o(peak_bin_o), .peak_power_o(peak_power_o),
    .busy_o(busy_o), .drop_o(drop_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] model_pow(input logic signed [AW-1:0] re, input logic signed [AW-1:0] im);
    logic signed [127:0] tr, ti, s;
    tr = re;
    ti = im;
    tr = tr >>> PS;
    ti = ti >>> PS;
    s = tr*tr + ti*ti;
    return s[PW-1:0];
  endfunction

  // Monitor: strobe scoreboard, peak scoreboard, hold stability, drop counting.
  initial begin
    exp_t e;
    logic hold_prev;
    logic [BW-1:0] pb_prev;
    logic [PW-1:0] pp_prev;
    hold_prev = 1'b0;
    pb_prev = '0;
    pp_prev = '0;
    forever begin
      @(negedge clk);
      if (drop_o) drop_cnt++;
      if (power_valid_o) begin
        if (pq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_strobe: got bin %0d expected none", power_bin_o);
        end else begin
          e = pq.pop_front();
          chk("power_bin", power_bin_o, e.bin);
          chk("power", power_o, e.pw);
        end
      end
      if (peak_valid_o) begin
        if (hold_prev) begin
          chk("hold_bin", peak_bin_o, pb_prev);
          chk("hold_pow", peak_power_o, pp_prev);
        end
        if (peak_ready_i) begin
          hold_prev = 1'b0;
          if (kq.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_peak: got bin %0d expected none", peak_bin_o);
          end else begin
            e = kq.pop_front();
            chk("peak_bin", peak_bin_o, e.bin);
            chk("peak_pow", peak_power_o, e.pw);
          end
        end else begin
          hold_prev = 1'b1;
          pb_prev = peak_bin_o;
          pp_prev = peak_power_o;
        end
      end else begin
        hold_prev = 1'b0;
      end
    end
  end

  function automatic logic signed [AW-1:0] rand_val();
    logic signed [AW-1:0] r;
    r = AW'({$urandom(), $urandom()});
    return r >>> $urandom_range(0, 40);
  endfunction

  task automatic set_zero();
    for (int i = 0; i < NB; i++) begin a_re[i] = '0; a_im[i] = '0; end
  endtask

  task automatic scramble();
    for (int i = 0; i < NB; i++) begin a_re[i] = rand_val(); a_im[i] = rand_val(); end
  endtask

  task automatic push_expect();
    logic [PW-1:0] p, best;
    int bb;
    best = '0;
    bb = 0;
    for (int b = 0; b < NB; b++) begin
      p = model_pow(a_re[b], a_im[b]);
      pq.push_back('{b, p});
      if (b == 0 || p > best) begin best = p; bb = b; end
    end
    kq.push_back('{bb, best});
  endtask

  task automatic issue();
    push_expect();
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    scramble();
  endtask

  task automatic ignored();
    scramble();
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_peak();
    int k = 0;
    while (!peak_valid_o && k < 100) begin @(posedge clk); #1; k++; end
    chk("wait_peak_timeout", peak_valid_o, 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy_o || peak_valid_o) && k < 300) begin @(posedge clk); #1; k++; end
    chk("wait_idle_timeout", busy_o | peak_valid_o, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_power_valid"}, power_valid_o, 0);
    chk({tag, "_power_bin"}, power_bin_o, 0);
    chk({tag, "_power"}, power_o, 0);
    chk({tag, "_peak_valid"}, peak_valid_o, 0);
    chk({tag, "_peak_bin"}, peak_bin_o, 0);
    chk({tag, "_peak_power"}, peak_power_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_drop"}, drop_o, 0);
  endtask

  initial begin
    int d0, k;
    logic [PW-1:0] big;
    set_zero();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // Single tone with latency profile
    set_zero();
    a_re[5] = AW'(3) << 16;
    a_im[5] = AW'(4) << 16;
    issue();
    chk("lat_pre", power_valid_o, 0);
    for (int i = 1; i <= NB; i++) begin
      @(posedge clk); #1;
      chk("lat_pv", power_valid_o, 1);
      chk("lat_peak", peak_valid_o, (i == NB) ? 1 : 0);
    end
    chk("tone_peak_bin", peak_bin_o, 5);
    chk("tone_peak_pow", peak_power_o, 25);
    @(posedge clk); #1;
    chk("lat_post", power_valid_o, 0);
    wait_idle();

    // Tie and sign
    for (int i = 0; i < NB; i++) begin a_re[i] = -1; a_im[i] = -1; end
    a_re[2] = -(AW'(7) << 16); a_im[2] = '0;
    a_re[9] = -(AW'(7) << 16); a_im[9] = '0;
    issue();
    wait_peak();
    chk("tie_peak_bin", peak_bin_o, 2);
    chk("tie_peak_pow", peak_power_o, 49);
    wait_idle();

    // Extremes
    set_zero();
    issue();
    wait_peak();
    chk("zero_peak_bin", peak_bin_o, 0);
    chk("zero_peak_pow", peak_power_o, 0);
    wait_idle();
    set_zero();
    a_re[15] = {1'b1, {(AW-1){1'b0}}};
    a_im[15] = {1'b1, {(AW-1){1'b0}}};
    issue();
    wait_peak();
    big = PW'(1) << 63;
    chk("ext_peak_bin", peak_bin_o, 15);
    chk("ext_peak_pow", peak_power_o, big);
    wait_idle();

    // Backpressure with rejected inputs in SCAN and HOLD
    peak_ready_i = 1'b0;
    scramble();
    d0 = drop_cnt;
    issue();
    repeat (3) begin @(posedge clk); #1; end
    ignored();
    wait_peak();
    repeat (10) begin @(posedge clk); #1; end
    ignored();
    repeat (3) begin @(posedge clk); #1; end
    chk("bp_drops", drop_cnt - d0, 2);
    peak_ready_i = 1'b1;
    wait_idle();

    // Back-to-back: new spectrum on the HOLD handshake edge
    peak_ready_i = 1'b0;
    scramble();
    issue();
    wait_peak();
    d0 = drop_cnt;
    peak_ready_i = 1'b1;
    issue();
    chk("b2b_busy", busy_o, 1);
    chk("b2b_peak_low", peak_valid_o, 0);
    @(posedge clk); #1;
    chk("b2b_restart_pv", power_valid_o, 1);
    chk("b2b_restart_bin", power_bin_o, 0);
    wait_idle();
    chk("b2b_drops", drop_cnt - d0, 0);

    // Reset in the middle of a scan
    scramble();
    issue();
    k = 0;
    while (!(power_valid_o && power_bin_o == 7) && k < 40) begin @(posedge clk); #1; k++; end
    chk("mid_found_bin7", power_valid_o && power_bin_o == 7, 1);
    rst_ni = 1'b0;
    @(posedge clk); #1;
    pq.delete();
    kq.delete();
    check_zero("midreset");
    rst_ni = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      chk("post_reset_no_peak", peak_valid_o, 0);
    end
    scramble();
    issue();
    wait_idle();

    // Randomized spectra with random backpressure
    for (int it = 0; it < 20; it++) begin
      scramble();
      if (it % 3 == 0) begin
        a_re[NB-1] = a_re[1];
        a_im[NB-1] = a_im[1];
      end
      issue();
      k = 0;
      while ((busy_o || peak_valid_o) && k < 300) begin
        peak_ready_i = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        k++;
      end
      chk("rand_idle_timeout", busy_o | peak_valid_o, 0);
      peak_ready_i = 1'b1;
    end

    repeat (3) begin @(posedge clk); #1; end
    chk("power_queue_empty", pq.size(), 0);
    chk("peak_queue_empty", kq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
